// File: rtl/toggle_pulse_decoder.sv
// Recovers one event per level change of an asynchronous toggle line, queues
// events behind a valid/ack handshake with sticky overrun. Optional GLITCH_FILTER_EN.
//
// state | meaning
// INIT  | chain filling after reset; adopt synchronised level, no pulse
// LOW   | decoded level is 0
// HIGH  | decoded level is 1
module toggle_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PEND_DEPTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             ack,
  input  logic             clr_ovr,
  output logic             pulse_out,
  output logic             level_out,
  output logic             evt_valid,
  output logic [2:0]       pend_cnt,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {INIT, LOW, HIGH} state_t;

  localparam logic [2:0]       INIT_TC  = 3'(SYNC_STAGES);
  localparam logic [2:0]       PEND_MAX = 3'(PEND_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic [2:0]             init_q, init_d;
  logic                   pulse_d;
  logic                   take;
  logic [2:0]             pend_d;
  logic                   ovr_set;

  assign s_sync    = sync_q[SYNC_STAGES-1];
  assign level_out = (state_q == HIGH);
  assign take      = evt_valid & ack;

`ifdef GLITCH_FILTER_EN
  // Set after the first edge on which s_sync disagrees with the state.
  logic flt_q, flt_d;

  always_ff @(posedge clk) begin
    if (rst) flt_q <= 1'b0;
    else     flt_q <= flt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    pulse_d = 1'b0;
`ifdef GLITCH_FILTER_EN
    flt_d   = 1'b0;
`endif
    case (state_q)
      INIT: begin
        if (init_q == INIT_TC) state_d = s_sync ? HIGH : LOW;
        else                   init_d  = init_q + 3'd1;
      end
      LOW: begin
        if (s_sync) begin
`ifdef GLITCH_FILTER_EN
          if (flt_q) begin
            state_d = HIGH;
            pulse_d = 1'b1;
          end else begin
            flt_d = 1'b1;
          end
`else
          state_d = HIGH;
          pulse_d = 1'b1;
`endif
        end
      end
      HIGH: begin
        if (!s_sync) begin
`ifdef GLITCH_FILTER_EN
          if (flt_q) begin
            state_d = LOW;
            pulse_d = 1'b1;
          end else begin
            flt_d = 1'b1;
          end
`else
          state_d = LOW;
          pulse_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = INIT;
        init_d  = 3'd0;
      end
    endcase
  end

  // Simultaneous pulse and ack cancel, so a full queue is not overrun then.
  always_comb begin
    pend_d  = pend_cnt;
    ovr_set = 1'b0;
    if (pulse_d && !take) begin
      if (pend_cnt == PEND_MAX) ovr_set = 1'b1;
      else                      pend_d  = pend_cnt + 3'd1;
    end else if (!pulse_d && take) begin
      pend_d = pend_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= INIT;
      init_q    <= 3'd0;
      pulse_out <= 1'b0;
      pend_cnt  <= 3'd0;
      evt_valid <= 1'b0;
      evt_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], tog_in};
      state_q   <= state_d;
      init_q    <= init_d;
      pulse_out <= pulse_d;
      pend_cnt  <= pend_d;
      evt_valid <= (pend_d != 3'd0);
      if (pulse_d) evt_cnt <= evt_cnt + CNT_ONE;
      overrun   <= ovr_set | (overrun & ~clr_ovr);
    end
  end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed self-checking bench for toggle_pulse_decoder (default parameters).
module tb_toggle_pulse_decoder;

`ifdef GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, tog_in, ack, clr_ovr;
  logic       pulse_out, level_out, evt_valid, overrun;
  logic [2:0] pend_cnt;
  logic [7:0] evt_cnt;

  int nerr = 0, nchk = 0, pulses = 0, maxp = 0, exp_evt = 0;
  int pexp[4] = '{1, 2, 3, 3};

  toggle_pulse_decoder #(.SYNC_STAGES(2), .CNT_W(8), .PEND_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .ack(ack), .clr_ovr(clr_ovr),
    .pulse_out(pulse_out), .level_out(level_out), .evt_valid(evt_valid),
    .pend_cnt(pend_cnt), .evt_cnt(evt_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (pulse_out) pulses++;
    if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, 32'(pulse_out), 0);
    chk({tag, "_level"}, 32'(level_out), 0);
    chk({tag, "_valid"}, 32'(evt_valid), 0);
    chk({tag, "_pend"},  32'(pend_cnt),  0);
    chk({tag, "_evt"},   32'(evt_cnt),   0);
    chk({tag, "_ovr"},   32'(overrun),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tog_in = 1'b1; ack = 1'b0; clr_ovr = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");

    // Release with tog_in high: INIT adopts HIGH silently
    rst = 1'b0; pulses = 0;
    repeat (6) step();
    chk("init_level", 32'(level_out), 1);
    chk("init_nopulse", pulses, 0);
    chk("init_evt", 32'(evt_cnt), 0);
    chk("init_valid", 32'(evt_valid), 0);

    // HIGH -> LOW
    tog_in = 1'b0; exp_evt++;
    repeat (LAT-1) step();
    chk("hl_early", 32'(pulse_out), 0);
    step();
    chk("hl_pulse", 32'(pulse_out), 1);
    chk("hl_level", 32'(level_out), 0);
    chk("hl_evt", 32'(evt_cnt), 32'(exp_evt));
    chk("hl_pend", 32'(pend_cnt), 1);
    chk("hl_valid", 32'(evt_valid), 1);
    step();
    chk("hl_single", 32'(pulse_out), 0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_pend", 32'(pend_cnt), 0);
    chk("ack_valid", 32'(evt_valid), 0);
    ack = 1'b1; step(); step(); ack = 1'b0;
    chk("ack_idle", 32'(pend_cnt), 0);

    // LOW -> HIGH
    tog_in = 1'b1; exp_evt++;
    repeat (LAT-1) step();
    chk("lh_early", 32'(pulse_out), 0);
    step();
    chk("lh_pulse", 32'(pulse_out), 1);
    chk("lh_level", 32'(level_out), 1);
    chk("lh_evt", 32'(evt_cnt), 32'(exp_evt));
    chk("lh_pend", 32'(pend_cnt), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lh_ack", 32'(pend_cnt), 0);

    // Four events without ack: saturate at 3, overrun on the 4th
    for (int i = 0; i < 4; i++) begin
      tog_in = ~tog_in; exp_evt++;
      repeat (5) step();
      chk("sat_pend", 32'(pend_cnt), 32'(pexp[i]));
      chk("sat_ovr", 32'(overrun), (i == 3) ? 1 : 0);
    end
    chk("sat_evt", 32'(evt_cnt), 32'(exp_evt));
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    chk("clr_ovr", 32'(overrun), 0);
    chk("clr_pend", 32'(pend_cnt), 3);

    // Full queue, pulse and ack on the same edge
    tog_in = ~tog_in; exp_evt++;
    repeat (LAT-1) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("full_pa_pulse", 32'(pulse_out), 1);
    chk("full_pa_pend", 32'(pend_cnt), 3);
    chk("full_pa_ovr", 32'(overrun), 0);
    chk("full_pa_evt", 32'(evt_cnt), 32'(exp_evt));
    ack = 1'b1; step(); step(); ack = 1'b0;
    chk("drain2", 32'(pend_cnt), 1);

    // One pending, pulse and ack together
    tog_in = ~tog_in; exp_evt++;
    repeat (LAT-1) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("one_pa_pend", 32'(pend_cnt), 1);
    chk("one_pa_ovr", 32'(overrun), 0);

    // Overrun set and clr_ovr on the same edge: set wins
    repeat (2) begin
      tog_in = ~tog_in; exp_evt++;
      repeat (5) step();
    end
    chk("refill", 32'(pend_cnt), 3);
    tog_in = ~tog_in; exp_evt++;
    repeat (LAT-1) step();
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    chk("setwins_ovr", 32'(overrun), 1);
    chk("setwins_evt", 32'(evt_cnt), 32'(exp_evt));
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    chk("setwins_clr", 32'(overrun), 0);

    // 256 events with ack held: counter wraps, queue never above 1
    ack = 1'b1;
    repeat (4) step();
    chk("wrap_drained", 32'(pend_cnt), 0);
    maxp = 0;
    repeat (256 - exp_evt) begin
      tog_in = ~tog_in;
      repeat (5) step();
    end
    chk("wrap_zero", 32'(evt_cnt), 0);
    repeat (exp_evt) begin
      tog_in = ~tog_in;
      repeat (5) step();
    end
    chk("wrap_evt", 32'(evt_cnt), 32'(exp_evt));
    chk("wrap_maxpend", maxp, 1);
    chk("wrap_ovr", 32'(overrun), 0);
    ack = 1'b0;

`ifdef GLITCH_FILTER_EN
    // One-cycle glitch is rejected
    pulses = 0;
    tog_in = ~tog_in; step(); tog_in = ~tog_in;
    repeat (8) step();
    chk("glitch_nopulse", pulses, 0);
    chk("glitch_evt", 32'(evt_cnt), 32'(exp_evt));
`endif

    // Reset while a transition is in the synchroniser
    tog_in = ~tog_in;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_all_zero("midrst");
    pulses = 0;
    repeat (8) step();
    chk("midrst_nopulse", pulses, 0);
    chk("midrst_level", 32'(level_out), 32'(tog_in));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_decoder.md
Name: toggle_pulse_decoder

Overview:
Receive-side counterpart of the team's toggle-encoding Moore FSM. The transmitter flips its output level once per input event; this block recovers one event per level change of tog_in. It synchronises tog_in into the clk domain, decodes each level change into a one-cycle pulse, and counts decoded events. Events are queued in a small pending counter and presented to the consumer through a valid/ack handshake, with sticky overrun detection.

Parameters:
SYNC_STAGES, 2, synchroniser depth on tog_in; legal range 2..4.
CNT_W, 8, width of the free-running event counter evt_cnt.
PEND_DEPTH, 3, maximum number of queued unacknowledged events; legal range 1..7.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
tog_in  input  1  toggle-encoded level from the transmitter; asynchronous to clk.
ack  input  1  consumer accepts one pending event when evt_valid=1.
clr_ovr  input  1  clears the sticky overrun flag.
pulse_out  output  1  one-cycle pulse per decoded level change.
level_out  output  1  current decoded (synchronised) level.
evt_valid  output  1  high while the pending count is nonzero.
pend_cnt  output  3  current pending event count, 0..PEND_DEPTH.
evt_cnt  output  CNT_W  total decoded events; wraps modulo 2^CNT_W.
overrun  output  1  sticky; set when an event arrives and the queue is full.

Behaviour:
- Reset (rst=1 at a clk edge): sync chain=0, FSM=INIT, init counter=0, pulse_out=0, level_out=0, evt_valid=0, pend_cnt=0, evt_cnt=0, overrun=0. Reset mid-operation discards pending events and any in-flight transition.
- Sync chain: SYNC_STAGES flops. s_sync is the last stage.
- FSM states:
  - INIT: held for SYNC_STAGES cycles after reset so the chain fills. Then adopt s_sync: go to LOW if 0, HIGH if 1. Sets level_out; no pulse.
  - LOW: if s_sync=1, go to HIGH and pulse.
  - HIGH: if s_sync=0, go to LOW and pulse.
  - Otherwise hold state.
- Latency:
  - tog_in change first sampled at edge k: pulse_out is high for the cycle after edge k+SYNC_STAGES.
  - level_out updates on that same edge.
- pulse_out: registered; never high for two consecutive cycles unless s_sync changed on both edges.
- evt_cnt: increments by 1 on every pulse, including dropped ones. Wraps from 2^CNT_W-1 to 0.
- Pending queue, evaluated per edge with p = pulse being registered this edge and a = evt_valid & ack:
  - p & !a: pend_cnt+1. If pend_cnt=PEND_DEPTH, the count stays put and overrun is set (event dropped).
  - !p & a: pend_cnt-1.
  - p & a: pend_cnt unchanged, even when full; no overrun.
  - ack while evt_valid=0: ignored.
- evt_valid = (pend_cnt != 0), registered together with pend_cnt.
- overrun: cleared on the edge where clr_ovr=1. If a new overrun occurs on the same edge, set wins.
- No X propagation: every register has a reset value; the default FSM branch returns to INIT.

Optional Feature:
Macro GLITCH_FILTER_EN.
- Defined: a level change is accepted only after s_sync differs from the current state on 2 consecutive edges. Changes lasting one synchronised cycle are ignored: no pulse, no count. Latency grows by exactly 1 cycle (pulse follows edge k+SYNC_STAGES+1).
- Undefined: every s_sync change is decoded as described in Behaviour. The filter register is not instantiated.

Test Plan:
- Reset with tog_in=1 held, release, no toggles -> INIT adopts HIGH after 2 cycles; level_out=1, pulse_out never asserts, evt_cnt=0.
- From LOW, SYNC_STAGES=2: tog_in 0->1 before edge k -> pulse_out high only in the cycle after edge k+2; evt_cnt=1, pend_cnt=1, evt_valid=1.
- 4 toggles spaced 5 cycles apart, ack=0 -> pend_cnt saturates at 3, overrun=1 after the 4th, evt_cnt=4. Then clr_ovr pulse -> overrun=0.
- Queue holds 1 event; pulse arrives on the same edge as ack -> pend_cnt stays 1, no overrun. With queue full plus pulse and ack together -> pend_cnt=3, overrun=0.
- 256 toggles with CNT_W=8, ack tied 1 -> evt_cnt wraps to 0, pend_cnt never exceeds 1, overrun=0.
- GLITCH_FILTER_EN defined: 1-cycle tog_in glitch -> no pulse. A 3-cycle-wide change -> one pulse at edge k+3. Assert rst mid-transition -> all outputs 0 on the next cycle.
